// File: rtl/bit_sched_pkg.sv
// ---------------------------------------------------------------------------
// bit_sched_pkg : shared types and defaults for the bit-pair scheduler
// Revision 1.0 : initial release
// ---------------------------------------------------------------------------
`default_nettype none

package bit_sched_pkg;

  localparam int DEFAULT_WIDTH = 8;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } sched_state_t;

endpackage

`default_nettype wire

// File: rtl/pair_detect_mealy.sv
// ---------------------------------------------------------------------------
// pair_detect_mealy : flags a serial bit equal to the bit before it
// Revision 1.0 : initial release
// ---------------------------------------------------------------------------
`default_nettype none

module pair_detect_mealy (
  input  logic clk,
  input  logic reset,
  input  logic clr,
  input  logic din_bit,
  input  logic din_en,
  output logic dout_bit
);

  logic prev_q, prev_d;
  logic have_q, have_d;

  always_comb begin
    prev_d = prev_q;
    have_d = have_q;
    if (clr) begin
      prev_d = 1'b0;
      have_d = 1'b0;
    end else if (din_en) begin
      prev_d = din_bit;
      have_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      prev_q <= 1'b0;
      have_q <= 1'b0;
    end else begin
      prev_q <= prev_d;
      have_q <= have_d;
    end
  end

  // The first bit of a word has no predecessor, so it can never match.
  assign dout_bit = din_en & have_q & (din_bit == prev_q);

endmodule

`default_nettype wire

// File: rtl/bit_pair_scheduler.sv
// ---------------------------------------------------------------------------
// bit_pair_scheduler : serializes a word and counts equal adjacent bit pairs
// Revision 1.0 : initial release
// ---------------------------------------------------------------------------
`default_nettype none

module bit_pair_scheduler
  import bit_sched_pkg::*;
#(
  parameter int WIDTH     = DEFAULT_WIDTH,
  parameter int MSB_FIRST = 1
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [WIDTH-1:0]        in_data,
  input  logic                    abort,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [$clog2(WIDTH):0]  out_count,
  output logic [WIDTH-1:0]        out_mask,
  output logic                    busy
);

  localparam int IDX_W = $clog2(WIDTH);
  localparam int CNT_W = $clog2(WIDTH) + 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(WIDTH - 1);

  sched_state_t     state_q, state_d;
  logic [WIDTH-1:0] word_q, word_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic [WIDTH-1:0] mask_q, mask_d;

  logic             serial_bit;
  logic [WIDTH-1:0] word_shifted;
  logic             det_clr;
  logic             det_en;
  logic             det_out;

  // The next serial bit always sits at one end of the captured word.
  always_comb begin
    if (MSB_FIRST != 0) begin
      serial_bit   = word_q[WIDTH-1];
      word_shifted = {word_q[WIDTH-2:0], 1'b0};
    end else begin
      serial_bit   = word_q[0];
      word_shifted = {1'b0, word_q[WIDTH-1:1]};
    end
  end

  pair_detect_mealy u_detect (
    .clk      (clk),
    .reset    (reset),
    .clr      (det_clr),
    .din_bit  (serial_bit),
    .din_en   (det_en),
    .dout_bit (det_out)
  );

  always_comb begin
    state_d = state_q;
    word_d  = word_q;
    idx_d   = idx_q;
    count_d = count_q;
    mask_d  = mask_q;
    det_clr = 1'b0;
    det_en  = 1'b0;

    case (state_q)
      IDLE: begin
        if (in_valid) begin
          word_d  = in_data;
          idx_d   = '0;
          count_d = '0;
          mask_d  = '0;
          det_clr = 1'b1;
          state_d = SHIFT;
        end
      end
      SHIFT: begin
        // Abort wins even on the last bit, so no result is ever published.
        if (abort) begin
          idx_d   = '0;
          count_d = '0;
          mask_d  = '0;
          det_clr = 1'b1;
          state_d = IDLE;
        end else begin
          det_en = 1'b1;
          word_d = word_shifted;
          if (det_out) begin
            count_d       = count_q + CNT_W'(1);
            mask_d[idx_q] = 1'b1;
          end
          if (idx_q == LAST_IDX) begin
            state_d = DONE;
          end else begin
            idx_d = idx_q + IDX_W'(1);
          end
        end
      end
      DONE: begin
        if (abort) begin
          count_d = '0;
          mask_d  = '0;
          det_clr = 1'b1;
          state_d = IDLE;
        end else if (out_ready) begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      word_q  <= '0;
      idx_q   <= '0;
      count_q <= '0;
      mask_q  <= '0;
    end else begin
      state_q <= state_d;
      word_q  <= word_d;
      idx_q   <= idx_d;
      count_q <= count_d;
      mask_q  <= mask_d;
    end
  end

  assign in_ready  = (state_q == IDLE);
  assign out_valid = (state_q == DONE);
  assign busy      = (state_q != IDLE);
  assign out_count = count_q;
  assign out_mask  = mask_q;

endmodule

`default_nettype wire

// File: tb/tb_bit_pair_scheduler.sv
// ---------------------------------------------------------------------------
// tb_bit_pair_scheduler : MSB-first and LSB-first instances against a model
// Revision 1.0 : initial release
// ---------------------------------------------------------------------------
`default_nettype none

module tb_bit_pair_scheduler;

  logic       clk = 1'b0;
  logic       reset;
  logic       in_valid;
  logic [7:0] in_data;
  logic       abort;
  logic       out_ready;

  logic       in_ready_m, out_valid_m, busy_m;
  logic [3:0] out_count_m;
  logic [7:0] out_mask_m;
  logic       in_ready_l, out_valid_l, busy_l;
  logic [3:0] out_count_l;
  logic [7:0] out_mask_l;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  bit_pair_scheduler #(.WIDTH(8), .MSB_FIRST(1)) dut_msb (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_ready  (in_ready_m),
    .in_data   (in_data),
    .abort     (abort),
    .out_valid (out_valid_m),
    .out_ready (out_ready),
    .out_count (out_count_m),
    .out_mask  (out_mask_m),
    .busy      (busy_m)
  );

  bit_pair_scheduler #(.WIDTH(8), .MSB_FIRST(0)) dut_lsb (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_ready  (in_ready_l),
    .in_data   (in_data),
    .abort     (abort),
    .out_valid (out_valid_l),
    .out_ready (out_ready),
    .out_count (out_count_l),
    .out_mask  (out_mask_l),
    .busy      (busy_l)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Serial order first, then compare each bit with its predecessor.
  function automatic void ref_model(input logic [7:0] w, input bit msb,
                                    output logic [3:0] c, output logic [7:0] m);
    bit s [8];
    for (int i = 0; i < 8; i++) s[i] = msb ? w[7-i] : w[i];
    c = 4'd0;
    m = 8'd0;
    for (int i = 1; i < 8; i++) begin
      if (s[i] == s[i-1]) begin
        m[i] = 1'b1;
        c    = c + 4'd1;
      end
    end
  endfunction

  task automatic run_word(input logic [7:0] d, input int stall);
    int         lat;
    logic [3:0] ec_m, ec_l;
    logic [7:0] em_m, em_l;
    ref_model(d, 1'b1, ec_m, em_m);
    ref_model(d, 1'b0, ec_l, em_l);
    check("in_ready_idle", in_ready_m, 1);
    in_valid = 1'b1;
    in_data  = d;
    tick();
    in_valid = 1'b0;
    check("busy_shift", busy_m, 1);
    check("in_ready_shift", in_ready_m, 0);
    lat = 0;
    while (!out_valid_m && lat < 20) begin
      in_data = 8'($urandom);
      tick();
      lat++;
    end
    check("latency", lat, 8);
    check("count_msb", out_count_m, ec_m);
    check("mask_msb", out_mask_m, em_m);
    check("valid_lsb", out_valid_l, 1);
    check("count_lsb", out_count_l, ec_l);
    check("mask_lsb", out_mask_l, em_l);
    for (int s = 0; s < stall; s++) begin
      tick();
      check("hold_valid", out_valid_m, 1);
      check("hold_count", out_count_m, ec_m);
      check("hold_mask", out_mask_m, em_m);
      check("hold_in_ready", in_ready_m, 0);
    end
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    check("in_ready_after_hs", in_ready_m, 1);
    check("valid_after_hs", out_valid_m, 0);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_in_ready"}, in_ready_m, 1);
    check({tag, "_out_valid"}, out_valid_m, 0);
    check({tag, "_busy"}, busy_m, 0);
    check({tag, "_count"}, out_count_m, 0);
    check({tag, "_mask"}, out_mask_m, 0);
  endtask

  initial begin
    reset     = 1'b0;
    in_valid  = 1'b0;
    in_data   = 8'h00;
    abort     = 1'b0;
    out_ready = 1'b0;
    #2;
    check_reset_outputs("por");
    tick();
    tick();
    reset = 1'b1;
    tick();

    run_word(8'h36, 0);
    run_word(8'hFF, 1);
    run_word(8'h55, 0);
    run_word(8'h03, 0);
    run_word(8'h36, 5);

    // abort while idle does nothing
    abort = 1'b1;
    tick();
    abort = 1'b0;
    check("abort_idle_ready", in_ready_m, 1);
    check("abort_idle_busy", busy_m, 0);

    // asynchronous reset in the middle of a word
    in_valid = 1'b1;
    in_data  = 8'hFF;
    tick();
    in_valid = 1'b0;
    repeat (3) tick();
    #2 reset = 1'b0;
    #1 check_reset_outputs("mid_rst");
    tick();
    tick();
    check_reset_outputs("held_rst");
    reset = 1'b1;
    tick();
    run_word(8'h00, 0);

    // abort on the final shift edge with the consumer ready
    in_valid = 1'b1;
    in_data  = 8'h36;
    tick();
    in_valid = 1'b0;
    repeat (7) tick();
    abort     = 1'b1;
    out_ready = 1'b1;
    tick();
    abort     = 1'b0;
    out_ready = 1'b0;
    check("abort_last_valid", out_valid_m, 0);
    check("abort_last_ready", in_ready_m, 1);
    check("abort_last_count", out_count_m, 0);
    check("abort_last_mask", out_mask_m, 0);
    repeat (3) tick();
    check("abort_last_still", out_valid_m, 0);
    run_word(8'hAA, 0);

    // abort while a result is waiting
    in_valid = 1'b1;
    in_data  = 8'hFF;
    tick();
    in_valid = 1'b0;
    repeat (8) tick();
    check("done_reached", out_valid_m, 1);
    abort = 1'b1;
    tick();
    abort = 1'b0;
    check("abort_done_valid", out_valid_m, 0);
    check("abort_done_count", out_count_m, 0);
    check("abort_done_mask", out_mask_m, 0);

    for (int n = 0; n < 40; n++) begin
      run_word(8'($urandom), int'($urandom_range(0, 3)));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

`default_nettype wire
